// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter (cpu / debug) in front of a single-port DM
// Optional feature: define DM_ARB_RR_EN for round-robin tie-breaking instead of cpu priority with starvation guard.
module dm_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_be,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_dbg;
    logic   winner_dbg;

`ifdef DM_ARB_RR_EN
    logic rr_last;

    // On a tie the port that was not served last goes next.
    always_comb begin
        grant_dbg = dbg_req && (!cpu_req || !rr_last);
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    always_comb begin
        grant_dbg = dbg_req && (!cpu_req || (starve_cnt == LIMIT));
    end
`endif

    assign cpu_stall = cpu_req && !cpu_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_req || dbg_req) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner_dbg <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
`ifdef DM_ARB_RR_EN
            rr_last    <= 1'b0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        winner_dbg <= grant_dbg;
                        mem_en     <= 1'b1;
                        mem_we     <= grant_dbg ? dbg_we    : cpu_we;
                        mem_be     <= grant_dbg ? dbg_be    : cpu_be;
                        mem_addr   <= grant_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata  <= grant_dbg ? dbg_wdata : cpu_wdata;
`ifdef DM_ARB_RR_EN
                        rr_last    <= grant_dbg;
`else
                        if (grant_dbg) begin
                            starve_cnt <= '0;
                        end else if (dbg_req && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
`endif
                    end
                end
                ISSUE: mem_en <= 1'b0;
                CAPTURE: begin
                    // Writes also capture the DM output so both ops share one path.
                    if (winner_dbg) begin
                        dbg_rdata <= mem_rdata;
                        dbg_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= mem_rdata;
                        cpu_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a DM model and transaction-level reference
module tb_dm_arbiter;
    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [3:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_we, dbg_ack;
    logic [3:0]        dbg_be;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    dm_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port DM: registered read of the pre-write word, byte-masked write.
    logic        dm_load;
    logic [31:0] dm [0:63];
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] seed_word(input int i);
        if (i == 4) return 32'h1234ABCD;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (dm_load) begin
            for (int i = 0; i < 64; i++) dm[i] <= seed_word(i);
        end else if (mem_en) begin
            mem_rdata <= dm[mem_addr[7:2]];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) dm[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_cpu_rd, exp_dbg_rd;
    int          starve;
    bit          rr_last;
    bit          won;
    bit [5:0]    order_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_op(input bit we, input logic [5:0] w, input logic [3:0] be, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_wdata = d;
        cpu_addr = '0; cpu_addr[7:0] = {w, 2'b00};
    endtask

    task automatic dbg_op(input bit we, input logic [5:0] w, input logic [3:0] be, input logic [31:0] d);
        dbg_req = 1'b1; dbg_we = we; dbg_be = be; dbg_wdata = d;
        dbg_addr = '0; dbg_addr[7:0] = {w, 2'b00};
    endtask

    task automatic rand_op(input bit to_dbg);
        bit          we = 1'($urandom_range(0, 1));
        logic [5:0]  w  = 6'($urandom_range(0, 63));
        logic [3:0]  be = 4'($urandom_range(1, 15));
        logic [31:0] d  = $urandom;
        if (to_dbg) dbg_op(we, w, be, d);
        else        cpu_op(we, w, be, d);
    endtask

    // Arbitration rule from the port-level view: lone requester wins; ties follow the policy.
    function automatic bit predict_dbg();
        if (cpu_req && dbg_req) begin
`ifdef DM_ARB_RR_EN
            return !rr_last;
`else
            return starve >= STARVE_LIMIT;
`endif
        end
        return dbg_req;
    endfunction

    task automatic step(input int lat, input string tag, output bit won_dbg);
        int          n = 0;
        int          en_cnt = 0;
        bit          got = 0;
        bit          exp_dbg = predict_dbg();
        bit          we = exp_dbg ? dbg_we : cpu_we;
        logic [5:0]  w  = exp_dbg ? dbg_addr[7:2] : cpu_addr[7:2];
        logic [3:0]  be = exp_dbg ? dbg_be : cpu_be;
        logic [31:0] wd = exp_dbg ? dbg_wdata : cpu_wdata;
        logic [31:0] old;
        while (!got && n < lat + 3) begin
            @(negedge clk);
            n++;
            if (mem_en) en_cnt++;
            if (cpu_ack || dbg_ack) got = 1;
            else if (cpu_req) chk({tag, " stall_wait"}, 32'(cpu_stall), 32'd1);
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " acks"}, 32'({cpu_ack, dbg_ack}), exp_dbg ? 32'd1 : 32'd2);
        chk({tag, " mem_en_pulses"}, 32'(en_cnt), 32'd1);
        chk({tag, " mem_addr"}, mem_addr, {24'd0, w, 2'b00});
        chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
        old = ref_mem[w];
        if (exp_dbg) exp_dbg_rd = old;
        else         exp_cpu_rd = old;
        chk({tag, " cpu_rdata"}, cpu_rdata, exp_cpu_rd);
        chk({tag, " dbg_rdata"}, dbg_rdata, exp_dbg_rd);
        chk({tag, " stall_ack"}, 32'(cpu_stall), 32'(cpu_req && exp_dbg));
        if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
        if (exp_dbg) starve = 0;
        else if (dbg_req && starve < STARVE_LIMIT) starve++;
        rr_last = exp_dbg;
        won_dbg = exp_dbg;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, " dbg_rdata"}, dbg_rdata, 32'd0);
        chk({tag, " acks"}, 32'({cpu_ack, dbg_ack}), 32'd0);
        chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'd0);
        chk({tag, " mem_ctl"}, 32'({mem_en, mem_we, mem_be}), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        rst = 1'b0; dm_load = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_be = 0; dbg_addr = 0; dbg_wdata = 0;
        starve = 0; rr_last = 0; exp_cpu_rd = 0; exp_dbg_rd = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
        repeat (3) @(negedge clk);
        dm_load = 1'b0;
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        cpu_op(0, 6'h04, 4'hF, 32'h0);
        step(3, "cpu_rd_10", won);
        chk("cpu_rd_10 value", cpu_rdata, 32'h1234ABCD);

        cpu_req = 0;
        dbg_op(1, 6'h08, 4'hF, 32'hDEADBEEF);
        step(4, "dbg_wr_20", won);
        dbg_req = 0;
        cpu_op(0, 6'h08, 4'hF, 32'h0);
        step(4, "cpu_rd_20", won);
        chk("cpu_rd_20 value", cpu_rdata, 32'hDEADBEEF);

        // Reset in the CAPTURE cycle of a cpu read abandons it.
        cpu_req = 0;
        repeat (2) @(negedge clk);
        cpu_op(0, 6'h11, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0; cpu_req = 0;
        #1 check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset no_ack", 32'({cpu_ack, dbg_ack}), 32'd0);
        end
        starve = 0; rr_last = 0; exp_cpu_rd = 0; exp_dbg_rd = 0;
        rand_op(0); cpu_we = 0;
        step(3, "rerequest", won);

        // Both ports held continuously.
`ifdef DM_ARB_RR_EN
        order_exp = 6'b010101;
`else
        order_exp = 6'b010000;
`endif
        rand_op(0); rand_op(1);
        for (int k = 0; k < 6; k++) begin
            step(4, "contend", won);
            chk("grant_order", 32'(won), 32'(order_exp[k]));
            rand_op(won);
        end

        dbg_req = 0;
        for (int k = 0; k < 3; k++) begin
            rand_op(0);
            step(4, "b2b_cpu", won);
        end

        for (int k = 0; k < 40; k++) begin
            step(4, "random", won);
            if ($urandom_range(0, 3) != 0) rand_op(won);
            else if (won) dbg_req = 0;
            else cpu_req = 0;
            if (won ? !cpu_req : !dbg_req)
                if ($urandom_range(0, 1) == 1) rand_op(!won);
            if (!cpu_req && !dbg_req) rand_op(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte address width on all address ports.
REQ-002 SHALL have parameter STARVE_LIMIT, 4, consecutive lost arbitrations after which dbg wins (1..15).
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request.
- cpu_we  in  1  1 = write.
- cpu_be  in  4  byte enables.
- cpu_addr  in  ADDR_W  address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  pipeline freeze.
- dbg_req, dbg_we, dbg_be(4), dbg_addr(ADDR_W), dbg_wdata(32)  in  same meaning for the loader/debug port.
- dbg_rdata  out  32; dbg_ack  out  1.
- mem_en, mem_we  out  1; mem_be  out  4; mem_addr  out  ADDR_W; mem_wdata  out  32  to single-port DM.
- mem_rdata  in  32  DM read data, valid the cycle after the edge that samples mem_en.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE, one state per cycle; no other transitions.
REQ-005 SHALL sample cpu_req/dbg_req only in IDLE; a request seen in any other state is ignored until the next IDLE.
REQ-006 SHALL, at the IDLE edge with any request, latch winner's we/be/addr/wdata into mem_* registers, set mem_en=1, go to ISSUE.
REQ-007 SHALL clear mem_en at the ISSUE edge; mem_we/mem_be/mem_addr/mem_wdata hold until the next grant.
REQ-008 SHALL, at the CAPTURE edge, load mem_rdata into the winner's rdata register (reads and writes) and set the winner's ack.
REQ-009 SHALL assert winner's ack for exactly the ACK cycle; the loser's ack and rdata register SHALL not change.
REQ-010 SHALL hold cpu_rdata/dbg_rdata until that port's next completion.
REQ-011 SHALL give latency: req high at IDLE edge E0 -> mem_en high E0..E1 -> ack high E2..E3; peak throughput one access per 4 cycles.
REQ-012 SHALL drive cpu_stall = cpu_req AND NOT cpu_ack, combinationally.
REQ-013 SHALL grant cpu over dbg on simultaneous requests, unless starve_cnt == STARVE_LIMIT.
REQ-014 SHALL increment 4-bit starve_cnt at each IDLE grant to cpu while dbg_req is high; SHALL clear it on any dbg grant; SHALL saturate at STARVE_LIMIT.
REQ-015 SHALL start a new transaction in IDLE if a requester keeps req high after its ack (back-to-back, no bubble beyond IDLE).
REQ-016 SHALL never assert cpu_ack and dbg_ack together, nor mem_en outside ISSUE.

Reset
REQ-017 SHALL, on rst low at any time including mid-transaction, immediately force state=IDLE, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cpu_ack=0, dbg_ack=0, cpu_rdata=0, dbg_rdata=0, starve_cnt=0, rr_last=0.
REQ-018 SHALL abandon an interrupted transaction with no ack after reset release; first IDLE sampling occurs at the first rising edge with rst high.

Configuration
REQ-019 SHALL, with DM_ARB_RR_EN defined, replace REQ-013/014 by round-robin: on simultaneous requests grant the port not granted last (rr_last, 0=cpu, 1=dbg; reset 0 so dbg wins first tie); no starve_cnt logic.
REQ-020 SHALL, without DM_ARB_RR_EN, implement fixed cpu priority with starvation counter per REQ-013/014; rr_last absent.

Verification
REQ-021 cpu read addr 0x10, DM[0x10]=0x1234ABCD -> mem_en one cycle, cpu_ack 3 cycles after request edge, cpu_rdata=0x1234ABCD, cpu_stall low in ack cycle.
REQ-022 dbg write addr 0x20 data 0xDEADBEEF be=0xF, then cpu read 0x20 -> cpu_rdata=0xDEADBEEF; dbg_ack once, cpu_ack once.
REQ-023 both requests held continuously, STARVE_LIMIT=4, macro off -> grant order cpu,cpu,cpu,cpu,dbg,cpu... ; macro on -> dbg,cpu,dbg,cpu.
REQ-024 rst low during CAPTURE of cpu read -> all outputs 0 within the reset cycle, no cpu_ack after release, re-request completes normally.
REQ-025 cpu_req held across ack for 3 accesses -> acks exactly 4 cycles apart, mem_en pulses 4 cycles apart, never two acks together.
